// File: rtl/mult_if.sv
// Execute-stage <-> multiplier bundle: mult/multu launch, operands, mfhi/mflo select and result.
interface mult_if;
  logic        startMultE;
  logic        signedE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic [1:0]  mfRegE;
  logic        multReady;
  logic [31:0] hiLoOutE;

  modport master (
    output startMultE, signedE, srcAE, srcBE, mfRegE,
    input  multReady, hiLoOutE
  );

  modport slave (
    input  startMultE, signedE, srcAE, srcBE, mfRegE,
    output multReady, hiLoOutE
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative 32x32 multiplier owning HI/LO; N=32/BITS_PER_CYCLE iterations plus one commit cycle.
// No backpressure: launches outside IDLE are dropped, the hazard unit stalls on multReady=0.
module mult_unit #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic clk,
  input  logic reset,
  mult_if.slave bus
);

  localparam int N     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_mag_a;
  logic [31:0]      r_mag_b;
  logic [63:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;

  logic             w_ready;
  logic             w_launch;
  logic             w_iter;
  logic             w_commit;
  logic [31:0]      w_mag_a_in;
  logic [31:0]      w_mag_b_in;
  logic             w_neg_in;
  logic [63:0]      w_pp;
  logic [5:0]       w_shamt;
  logic [63:0]      w_acc_nxt;
  logic [63:0]      w_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_launch    = 1'b0;
    w_iter      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.startMultE) begin
          w_launch    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_iter = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sign is stripped up front so the iteration is a plain unsigned shift-add;
  // -2^31 maps to 0x80000000, which is still a valid unsigned magnitude.
  assign w_mag_a_in = (bus.signedE && bus.srcAE[31]) ? -bus.srcAE : bus.srcAE;
  assign w_mag_b_in = (bus.signedE && bus.srcBE[31]) ? -bus.srcBE : bus.srcBE;
  assign w_neg_in   = bus.signedE & (bus.srcAE[31] ^ bus.srcBE[31]);

  assign w_pp      = {32'b0, r_mag_a} * {{(64-BITS_PER_CYCLE){1'b0}}, r_mag_b[BITS_PER_CYCLE-1:0]};
  assign w_shamt   = 6'(BITS_PER_CYCLE) * 6'(r_cnt);
  assign w_acc_nxt = r_acc + (w_pp << w_shamt);
  assign w_result  = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mag_a <= 32'd0;
      r_mag_b <= 32'd0;
      r_acc   <= 64'd0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else if (w_launch) begin
      r_mag_a <= w_mag_a_in;
      r_mag_b <= w_mag_b_in;
      r_acc   <= 64'd0;
      r_cnt   <= '0;
      r_neg   <= w_neg_in;
    end else if (w_iter) begin
      r_acc   <= w_acc_nxt;
      r_mag_b <= r_mag_b >> BITS_PER_CYCLE;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // HI/LO change only on the commit cycle, so mfhi/mflo never observe a partial sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_result[63:32];
      r_lo <= w_result[31:0];
    end
  end

  always_comb begin
    bus.hiLoOutE = 32'd0;
    case (bus.mfRegE)
      2'b10:   bus.hiLoOutE = r_hi;
      2'b01:   bus.hiLoOutE = r_lo;
      default: bus.hiLoOutE = 32'd0;
    endcase
  end

  assign bus.multReady = w_ready;

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative 32x32 multiplier owning the HI/LO register pair, sitting beside the execute stage of the pipelined MIPS core. It accepts a `mult`/`multu` launch from execute, computes the 64-bit product over several cycles, and signals completion to the hazard detector. It returns HI or LO to execute for `mfhi`/`mflo`.

## Interface
- `BITS_PER_CYCLE`, default 4: multiplier bits consumed per BUSY cycle. Legal values are 1, 2, 4 and 8. N = 32/BITS_PER_CYCLE iterations.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. 0 clears all state immediately.
- `startMultE` input 1: launch a multiply. Sampled only in IDLE.
- `signedE` input 1: 1 selects `mult` (two's complement), 0 selects `multu`.
- `srcAE` input 32: multiplicand.
- `srcBE` input 32: multiplier.
- `mfRegE` input 2: read select. 2'b10 reads HI, 2'b01 reads LO, 2'b00 and 2'b11 read 0.
- `multReady` output 1: 1 when the unit is idle and HI/LO hold the final result.
- `hiLoOutE` output 32: combinational read of HI or LO, as selected by `mfRegE`.

## Operation
- State registers: `state` (IDLE, BUSY, FINISH), `hi`, `lo`, `magA`, `magB`, `acc[63:0]`, `cnt`, `neg`.
- IDLE: `multReady`=1.
  - If `startMultE`=1, latch the operands:
    - `magA` = signedE && srcAE[31] ? -srcAE : srcAE. `magB` is formed the same way from srcBE.
    - `neg` = signedE & (srcAE[31] ^ srcBE[31]).
    - `acc`=0, `cnt`=0. Go to BUSY.
- BUSY: `multReady`=0.
  - Each cycle: `acc` += ({32'b0, magA} * magB[BITS_PER_CYCLE-1:0]) << (BITS_PER_CYCLE*cnt).
  - Then `magB` >>= BITS_PER_CYCLE and `cnt`++.
  - After the N-th iteration (cnt reaches N-1 and updates), go to FINISH.
- FINISH: `multReady`=0. {hi,lo} <= neg ? -acc : acc (64-bit two's complement). Go to IDLE.
- Arithmetic is unsigned 64-bit throughout, and all carries are kept.
  - Magnitude of -2^31 is 0x80000000, interpreted as unsigned. No overflow is possible.
- `startMultE` in BUSY or FINISH is ignored. The hazard detector stalls the issuing instruction until `multReady`=1.
- `hiLoOutE` always reflects the committed `hi`/`lo`, never `acc`.
  - In BUSY it returns the previous result. The hazard unit stalls `mf*` while `multReady`=0.
- HI and LO are written only in FINISH. Nothing else modifies them.
- `srcAE`, `srcBE` and `signedE` may change freely after the launch edge.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE, hi=lo=acc=0, cnt=0, neg=0.
  - `multReady`=1. `hiLoOutE`=0 for any select.
- Reset asserted mid-operation aborts immediately. The old HI/LO contents are lost (cleared to 0).
- Launch edge E0 samples `startMultE`=1. `multReady` falls after E0.
  - Edges E1..EN perform the iterations. Edge EN+1 (FINISH) writes HI/LO and returns to IDLE.
  - `multReady` is 0 for exactly N+1 cycles. It is 1 again in the cycle after EN+1, with the new HI/LO visible.
  - Default N=8 gives 9 busy cycles.
- A new launch may be sampled in the first cycle `multReady`=1. Back-to-back operations therefore cost N+2 cycles each.
- Launch and `mfRegE` read in the same IDLE cycle: the read returns the old value.
- `hiLoOutE` has zero latency from `mfRegE`, `hi` and `lo`. It is purely combinational.

## Test plan
- Reset: hold `reset`=0 with random inputs -> `multReady`=1, `hiLoOutE`=0 for all `mfRegE`. Release, read HI and LO -> 0.
- Unsigned max: multu 0xFFFFFFFF x 0xFFFFFFFF -> `multReady` low exactly 9 cycles (default). Then HI=0xFFFFFFFE, LO=0x00000001.
- Signed corners:
  - mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
  - mult 0xFFFFFFFF x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFB.
  - multu 0xFFFFFFFF x 5 -> HI=0x00000004, LO=0xFFFFFFFB.
- Busy protection:
  - Launch 3x7, then pulse `startMultE` with 9x9 during BUSY -> result is HI=0, LO=21.
  - During BUSY, `mfRegE`=01 returns the previous LO.
- Abort: launch 0x12345678 x 0x9ABCDEF0 and assert `reset`=0 at iteration 4 -> immediate IDLE, `multReady`=1, HI=LO=0. The next multu 2x3 -> LO=6.
- Parameter sweep: BITS_PER_CYCLE in {1, 2, 8} with 1000 random signed/unsigned pairs -> busy count is 33, 17 and 5 respectively, and every product matches the 64-bit reference.
